// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART blocks and the baud increment helper
// used both by the tick generator and by software-facing register defaults.
package uart_pkg;

  localparam int OVS   = 16;
  localparam int OVS_W = 4;

  // Rounded phase increment: round(baud * ovs * 2^acc_w / f_clk).
  function automatic longint unsigned baud_inc(
    input longint unsigned f_clk,
    input longint unsigned baud,
    input longint unsigned ovs,
    input int unsigned     acc_w
  );
    longint unsigned num;
    num = (baud * ovs) << acc_w;
    return (num + (f_clk >> 1)) / f_clk;
  endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// baud_phase_acc: fractional phase accumulator. Produces the carry of the
// current add; resync clears the phase and wins over en, en=0 holds it.
module baud_phase_acc
  import uart_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             resync_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             carry_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum_s;

  // One extra bit holds the carry; nothing can overflow beyond it.
  assign sum_s = {1'b0, acc_q} + {1'b0, inc_i};

  // Next accumulator value and carry of this cycle's add.
  always_comb begin
    acc_d   = acc_q;
    carry_o = 1'b0;
    if (resync_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d   = sum_s[ACC_W-1:0];
      carry_o = sum_s[ACC_W];
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: programmable fractional baud tick generator for UART TX/RX.
// Emits an oversample tick, a bit tick and a mid-bit sample tick, all
// registered. Increment changes are staged so a bit period never mixes rates.
// Optional feature macro: BAUD_CLK_OUT_EN (registered bit-rate square wave on
// clk_out); when undefined clk_out is tied low.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int F_CLK        = 50000000,
  parameter int BAUD_DEFAULT = 9600,
  parameter int OVS          = uart_pkg::OVS,
  parameter int OVS_W        = uart_pkg::OVS_W,
  parameter int ACC_W        = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             resync,
  input  logic [ACC_W-1:0] inc_in,
  input  logic             inc_load,
  output logic             inc_pending,
  output logic             ovs_tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic [OVS_W-1:0] ovs_phase,
  output logic             clk_out
);

  localparam logic [ACC_W-1:0] INC_DEFAULT =
    ACC_W'(baud_inc(64'(F_CLK), 64'(BAUD_DEFAULT), 64'(OVS), 32'(ACC_W)));
  localparam logic [OVS_W-1:0] PHASE_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] PHASE_MID  = OVS_W'(OVS / 2 - 1);

  logic             carry_s;
  logic             load_s;
  logic             apply_s;
  logic [OVS_W-1:0] ovs_phase_q, ovs_phase_d;
  logic             ovs_tick_q, ovs_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic [ACC_W-1:0] inc_active_q, inc_active_d;
  logic [ACC_W-1:0] inc_stage_q, inc_stage_d;
  logic             inc_pending_q, inc_pending_d;

  baud_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk_i    (clk),
    .rst_n_i  (reset),
    .en_i     (en),
    .resync_i (resync),
    .inc_i    (inc_active_q),
    .carry_o  (carry_s)
  );

  // Phase counter and tick decode; carry is already gated by en and resync.
  always_comb begin
    ovs_phase_d = ovs_phase_q;
    ovs_tick_d  = 1'b0;
    bit_tick_d  = 1'b0;
    mid_tick_d  = 1'b0;
    if (resync) begin
      ovs_phase_d = '0;
    end else if (carry_s) begin
      ovs_tick_d  = 1'b1;
      bit_tick_d  = (ovs_phase_q == PHASE_LAST);
      mid_tick_d  = (ovs_phase_q == PHASE_MID);
      ovs_phase_d = ovs_phase_q + OVS_W'(1);
    end else begin
      ovs_phase_d = ovs_phase_q;
    end
  end

  // A zero increment would stall the generator, so such loads are dropped.
  assign load_s  = inc_load && (inc_in != '0);
  // New rates take effect only at a bit boundary, a resync or while idle.
  assign apply_s = bit_tick_d || resync || !en;

  // Increment staging: a same-cycle load wins over the staged value.
  always_comb begin
    inc_active_d  = inc_active_q;
    inc_stage_d   = inc_stage_q;
    inc_pending_d = inc_pending_q;
    if (apply_s) begin
      if (load_s) begin
        inc_active_d = inc_in;
      end else if (inc_pending_q) begin
        inc_active_d = inc_stage_q;
      end else begin
        inc_active_d = inc_active_q;
      end
      inc_pending_d = 1'b0;
    end else if (load_s) begin
      inc_stage_d   = inc_in;
      inc_pending_d = 1'b1;
    end else begin
      inc_pending_d = inc_pending_q;
    end
  end

  // Phase, tick and increment registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovs_phase_q   <= '0;
      ovs_tick_q    <= 1'b0;
      bit_tick_q    <= 1'b0;
      mid_tick_q    <= 1'b0;
      inc_active_q  <= INC_DEFAULT;
      inc_stage_q   <= '0;
      inc_pending_q <= 1'b0;
    end else begin
      ovs_phase_q   <= ovs_phase_d;
      ovs_tick_q    <= ovs_tick_d;
      bit_tick_q    <= bit_tick_d;
      mid_tick_q    <= mid_tick_d;
      inc_active_q  <= inc_active_d;
      inc_stage_q   <= inc_stage_d;
      inc_pending_q <= inc_pending_d;
    end
  end

  assign ovs_phase   = ovs_phase_q;
  assign ovs_tick    = ovs_tick_q;
  assign bit_tick    = bit_tick_q;
  assign mid_tick    = mid_tick_q;
  assign inc_pending = inc_pending_q;

`ifdef BAUD_CLK_OUT_EN
  logic clk_out_q;

  // Square wave tracking the phase MSB: low for the first half of each bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= ovs_phase_d[OVS_W-1];
    end
  end

  assign clk_out = clk_out_q;
`else
  assign clk_out = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: table vectors, a scoreboard fed by a behavioural model,
// and hand sequences for rate change, resync, reset and clk_out.
module tb_baud_tick_gen;

  localparam int ACC_MOD = 256;     // 2^ACC_W for the small instance
  localparam int INC_DEF = 32;      // 390625 * 16 * 256 / 50e6
`ifdef BAUD_CLK_OUT_EN
  localparam bit CKO_EN = 1'b1;
`else
  localparam bit CKO_EN = 1'b0;
`endif

  typedef struct packed {
    logic       ovs;
    logic       bt;
    logic       mid;
    logic [3:0] phase;
    logic       pend;
    logic       cko;
  } exp_t;

  typedef struct {
    logic       r;
    logic       e;
    logic       s;
    logic       l;
    logic [7:0] ii;
    exp_t       x;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, en, resync, inc_load;
  logic [7:0] inc_in;
  logic       inc_pending, ovs_tick, bit_tick, mid_tick, clk_out;
  logic [3:0] ovs_phase;

  logic        d_reset, d_en;
  logic        d_pending, d_ovs, d_bit, d_mid, d_clk_out;
  logic [3:0]  d_phase;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .F_CLK(50000000), .BAUD_DEFAULT(390625), .OVS(16), .OVS_W(4), .ACC_W(8)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .resync(resync), .inc_in(inc_in),
    .inc_load(inc_load), .inc_pending(inc_pending), .ovs_tick(ovs_tick),
    .bit_tick(bit_tick), .mid_tick(mid_tick), .ovs_phase(ovs_phase),
    .clk_out(clk_out)
  );

  baud_tick_gen u_def (
    .clk(clk), .reset(d_reset), .en(d_en), .resync(1'b0), .inc_in(24'd0),
    .inc_load(1'b0), .inc_pending(d_pending), .ovs_tick(d_ovs),
    .bit_tick(d_bit), .mid_tick(d_mid), .ovs_phase(d_phase),
    .clk_out(d_clk_out)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  int   ovs_t[$];
  int   bit_t[$];
  int   mid_t[$];
  vec_t tab[11];

  int unsigned m_acc, m_inc, m_stage;
  int          m_phase;
  bit          m_pend;

  function automatic vec_t mkv(input logic r, e, s, l, input logic [7:0] ii,
                               input logic ovs, bt, mid, input logic [3:0] ph,
                               input logic pend);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.l = l; v.ii = ii;
    v.x.ovs = ovs; v.x.bt = bt; v.x.mid = mid; v.x.phase = ph;
    v.x.pend = pend; v.x.cko = 1'b0;
    return v;
  endfunction

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -100000;
  endfunction

  task automatic model_step(input logic r, e, s, l, input logic [7:0] ii,
                            output exp_t x);
    int unsigned sum;
    bit ld, apply;
    x = '0;
    if (!r) begin
      m_acc = 0; m_phase = 0; m_inc = INC_DEF; m_pend = 1'b0; m_stage = 0;
    end else begin
      if (s) begin
        m_acc = 0; m_phase = 0;
      end else if (e) begin
        sum = m_acc + m_inc;
        if (sum >= ACC_MOD) begin
          x.ovs = 1'b1;
          x.bt  = (m_phase == 15);
          x.mid = (m_phase == 7);
          m_phase = (m_phase + 1) % 16;
        end
        m_acc = sum % ACC_MOD;
      end
      ld    = l && (ii != 8'd0);
      apply = s || !e || x.bt;
      if (apply) begin
        if (ld) m_inc = ii;
        else if (m_pend) m_inc = m_stage;
        m_pend = 1'b0;
      end else if (ld) begin
        m_stage = ii; m_pend = 1'b1;
      end
    end
    x.phase = 4'(m_phase);
    x.pend  = m_pend;
    x.cko   = CKO_EN && (m_phase >= 8);
  endtask

  task automatic check_out(input string nm);
    exp_t a, x;
    a.ovs = ovs_tick; a.bt = bit_tick; a.mid = mid_tick; a.phase = ovs_phase;
    a.pend = inc_pending; a.cko = clk_out;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s cyc %0d: scoreboard empty", nm, cyc);
    end else begin
      x = sb_q.pop_front();
      if (a !== x) begin
        n_bad++;
        $display("FAIL %s cyc %0d: got ovs=%b bit=%b mid=%b ph=%0d pend=%b cko=%b want ovs=%b bit=%b mid=%b ph=%0d pend=%b cko=%b",
                 nm, cyc, a.ovs, a.bt, a.mid, a.phase, a.pend, a.cko,
                 x.ovs, x.bt, x.mid, x.phase, x.pend, x.cko);
      end
    end
    if (ovs_tick === 1'b1) ovs_t.push_back(cyc);
    if (bit_tick === 1'b1) bit_t.push_back(cyc);
    if (mid_tick === 1'b1) mid_t.push_back(cyc);
  endtask

  task automatic step(input logic r, e, s, l, input logic [7:0] ii, input string nm);
    exp_t x;
    reset = r; en = e; resync = s; inc_load = l; inc_in = ii;
    model_step(r, e, s, l, ii, x);
    sb_q.push_back(x);
    @(posedge clk); #1; cyc++;
    check_out(nm);
  endtask

  task automatic step_tab(input vec_t v, input string nm);
    exp_t x;
    reset = v.r; en = v.e; resync = v.s; inc_load = v.l; inc_in = v.ii;
    model_step(v.r, v.e, v.s, v.l, v.ii, x);
    sb_q.push_back(v.x);
    @(posedge clk); #1; cyc++;
    check_out(nm);
  endtask

  task automatic run(input int n, input string nm);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, nm);
  endtask

  task automatic run_to_phase(input int ph, input string nm);
    int k;
    k = 0;
    while (m_phase != ph && k < 200) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, nm);
      k++;
    end
    if (m_phase != ph) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: phase %0d not reached, at %0d", nm, ph, m_phase);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic clear_stamps();
    ovs_t.delete(); bit_t.delete(); mid_t.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, hi, n, c_ovs, c_bit, c_mid;
    reset = 1'b0; en = 1'b0; resync = 1'b0; inc_load = 1'b0; inc_in = 8'd0;
    d_reset = 1'b0; d_en = 1'b0;

    // r e s l ii | ovs bit mid ph pend
    tab[0]  = mkv(0, 0, 0, 0, 8'd0,  0, 0, 0, 4'd0, 0);
    tab[1]  = mkv(0, 1, 0, 1, 8'd64, 0, 0, 0, 4'd0, 0);
    tab[2]  = mkv(1, 0, 0, 1, 8'd64, 0, 0, 0, 4'd0, 0);
    tab[3]  = mkv(1, 1, 0, 0, 8'd0,  0, 0, 0, 4'd0, 0);
    tab[4]  = mkv(1, 1, 0, 0, 8'd0,  0, 0, 0, 4'd0, 0);
    tab[5]  = mkv(1, 1, 0, 1, 8'd0,  0, 0, 0, 4'd0, 0);
    tab[6]  = mkv(1, 1, 0, 0, 8'd0,  1, 0, 0, 4'd1, 0);
    tab[7]  = mkv(1, 1, 0, 1, 8'd32, 0, 0, 0, 4'd1, 1);
    tab[8]  = mkv(1, 0, 0, 0, 8'd0,  0, 0, 0, 4'd1, 0);
    tab[9]  = mkv(1, 1, 0, 0, 8'd0,  0, 0, 0, 4'd1, 0);
    tab[10] = mkv(1, 1, 1, 0, 8'd0,  0, 0, 0, 4'd0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) step_tab(tab[i], "table");

    // Rate 64 loaded while idle: tick every 4 cycles, bit every 64.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd64, "load_idle");
    clear_stamps();
    t0 = cyc;
    run(140, "rate64");
    chk_int("first_ovs_after_en", at(ovs_t, 0) - t0, 4);
    chk_int("ovs_period", at(ovs_t, 1) - at(ovs_t, 0), 4);
    chk_int("bit_period", at(bit_t, 1) - at(bit_t, 0), 64);
    chk_int("mid_after_bit", at(mid_t, 1) - at(bit_t, 0), 32);

    // Load 32 at phase 5: current bit stays 64 cycles, next one is 128.
    run_to_phase(5, "to_phase5");
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd32, "load_mid_bit");
    chk_int("pending_set", int'(inc_pending), 1);
    run(200, "rate_switch");
    chk_int("bit_before_switch", at(bit_t, 2) - at(bit_t, 1), 64);
    chk_int("bit_after_switch", at(bit_t, 3) - at(bit_t, 2), 128);
    chk_int("pending_cleared", int'(inc_pending), 0);

    // Resync at phase 11 applies a pending 64 and restarts the bit.
    run_to_phase(11, "to_phase11");
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd64, "load_before_resync");
    clear_stamps();
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, "resync");
    t0 = cyc;
    chk_int("resync_phase", int'(ovs_phase), 0);
    chk_int("resync_pending", int'(inc_pending), 0);
    run(100, "after_resync");
    chk_int("resync_to_bit", at(bit_t, 0) - t0, 64);
    n = 0;
    foreach (ovs_t[i]) if (ovs_t[i] <= at(bit_t, 0)) n++;
    chk_int("ovs_ticks_to_bit", n, 16);

    // Reset mid-bit with a pending load: everything clears, default rate.
    run_to_phase(6, "to_phase6");
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd32, "load_before_reset");
    step_tab(mkv(0, 1, 0, 0, 8'd0, 0, 0, 0, 4'd0, 0), "reset_mid_bit");
    clear_stamps();
    t0 = cyc;
    run(40, "post_reset");
    chk_int("post_reset_first_ovs", at(ovs_t, 0) - t0, 8);
    chk_int("post_reset_ovs_period", at(ovs_t, 1) - at(ovs_t, 0), 8);

    // clk_out over one full bit at rate 64.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd64, "load_for_clk_out");
    run(64, "clk_out_warm");
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "clk_out_bit");
      if (clk_out === 1'b1) hi++;
    end
    chk_int("clk_out_high_cycles", hi, CKO_EN ? 32 : 0);

    // Default build (9600 baud, ACC_W=24): 20000 cycles.
    d_reset = 1'b1; d_en = 1'b1;
    c_ovs = 0; c_bit = 0; c_mid = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (d_ovs === 1'b1) c_ovs++;
      if (d_bit === 1'b1) c_bit++;
      if (d_mid === 1'b1) c_mid++;
    end
    chk_int("default_ovs_count", c_ovs, 61);
    chk_int("default_bit_count", c_bit, 3);
    chk_int("default_mid_count", c_mid, 4);
    chk_int("default_phase", int'(d_phase), 13);
    chk_int("default_pending", int'(d_pending), 0);
    chk_int("default_clk_out", int'(d_clk_out), CKO_EN ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
